// File: rtl/rvfi_bus_pkg.sv
// Shared types and constants for the RVFI bus arbiter.
//   arb_state_e : arbiter FSM states
//   PORT_IFETCH : requester index of the instruction-fetch port
//   PORT_DATA   : requester index of the data port
//   grant_idx   : converts a one-hot (or zero) 2-bit grant into a port index
package rvfi_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int unsigned PORT_IFETCH = 0;
  localparam int unsigned PORT_DATA   = 1;
  localparam int unsigned NUM_PORTS   = 2;

  function automatic logic grant_idx(input logic [NUM_PORTS-1:0] grant);
    return grant[PORT_DATA];
  endfunction

endpackage

// File: rtl/rvfi_bus_arbiter_if.sv
// Bundle of every bus signal around the arbiter: the two requester ports,
// the response path back to them, and the single memory port.
//   slave  : the arbiter's view (takes requests, drives memory)
//   master : the environment's view (requesters plus memory model)
// Port p of the packed request vectors lives at [p*XLEN +: XLEN].
interface rvfi_bus_arbiter_if #(
  parameter int XLEN = 32
) ();
  localparam int STRB = XLEN / 8;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*XLEN-1:0] req_addr;
  logic [2*XLEN-1:0] req_wdata;
  logic [2*STRB-1:0] req_wstrb;

  logic [1:0]        rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_error;

  logic              mem_valid;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [STRB-1:0]   mem_wstrb;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  logic              timeout_seen;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata,
    output timeout_seen
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata,
    input  timeout_seen
  );

endinterface

// File: rtl/rvfi_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker.
//   clock  : rising-edge clock
//   reset  : asynchronous, active-high; port 0 preferred after reset
//   req    : request per port
//   update : a grant is being taken this cycle; advance the priority
//   grant  : one-hot (or zero) combinational grant
module rvfi_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // prio_q = 1 means port 1 wins a tie
  logic prio_q;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = prio_q ? 2'b10 : 2'b01;
    end
  end

  // Only a taken grant moves the priority; the port just served loses the next tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else if (update && (grant != 2'b00)) begin
      prio_q <= grant[0];
    end
  end

endmodule

// File: rtl/rvfi_bus_arbiter.sv
// Shares one single-port memory model between a core's instruction fetch
// (port 0) and data port (port 1). One transaction outstanding, round-robin
// between the ports, watchdog abort when the memory never answers.
//   clock : rising-edge clock
//   reset : asynchronous, active-high; drops any transaction in flight
//   bus   : requester, response and memory signals (slave modport)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; grant + req_ready combinational
// ISSUE | mem_valid held with latched fields until mem_ready
// WAIT  | waiting for mem_rvalid, watchdog counting
// RESP  | one-cycle rsp_valid pulse to the granted port
module rvfi_bus_arbiter
  import rvfi_bus_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  rvfi_bus_arbiter_if.slave  bus
);

  localparam int STRB = XLEN / 8;
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  arb_state_e      state_q, state_d;
  logic [1:0]      grant;
  logic            arb_update;
  logic            accept;
  logic            rsp_ok;
  logic            rsp_abort;

  logic            gnt_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [STRB-1:0] mem_wstrb_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic            rsp_error_q;
  logic            timeout_seen_q;

  rvfi_rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (bus.req_valid),
    .update (arb_update),
    .grant  (grant)
  );

  always_comb begin
    state_d       = state_q;
    arb_update    = 1'b0;
    accept        = 1'b0;
    rsp_ok        = 1'b0;
    rsp_abort     = 1'b0;
    bus.req_ready = 2'b00;
    bus.mem_valid = 1'b0;
    bus.rsp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        if (bus.req_valid != 2'b00) begin
          accept        = 1'b1;
          arb_update    = 1'b1;
          bus.req_ready = grant;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_valid = 1'b1;
        if (bus.mem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A response arriving in the same cycle as the timeout still wins.
        if (bus.mem_rvalid) begin
          rsp_ok  = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_MAX) begin
          rsp_abort = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid[gnt_q] = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch: the granted port's fields stay frozen until the next grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else if (accept) begin
      gnt_q       <= grant_idx(grant);
      mem_addr_q  <= grant[PORT_DATA] ? bus.req_addr[2*XLEN-1:XLEN]  : bus.req_addr[XLEN-1:0];
      mem_wdata_q <= grant[PORT_DATA] ? bus.req_wdata[2*XLEN-1:XLEN] : bus.req_wdata[XLEN-1:0];
      mem_wstrb_q <= grant[PORT_DATA] ? bus.req_wstrb[2*STRB-1:STRB] : bus.req_wstrb[STRB-1:0];
    end
  end

  // Watchdog: cleared on the memory accept, saturates at TIMEOUT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if ((state_q == ISSUE) && bus.mem_ready) begin
      cnt_q <= '0;
    end else if ((state_q == WAIT) && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Response register: holds its value between responses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_rdata_q    <= '0;
      rsp_error_q    <= 1'b0;
      timeout_seen_q <= 1'b0;
    end else if (rsp_ok) begin
      rsp_rdata_q <= bus.mem_rdata;
      rsp_error_q <= 1'b0;
    end else if (rsp_abort) begin
      rsp_rdata_q    <= '0;
      rsp_error_q    <= 1'b1;
      timeout_seen_q <= 1'b1;
    end
  end

  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_wstrb    = mem_wstrb_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_error    = rsp_error_q;
  assign bus.timeout_seen = timeout_seen_q;

endmodule

// File: tb/tb_rvfi_bus_arbiter.sv
module tb_rvfi_bus_arbiter;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  rvfi_bus_arbiter_if #(.XLEN(32)) bus ();

  rvfi_bus_arbiter #(.XLEN(32), .TIMEOUT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid  = 2'b00;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wstrb  = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #3;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=0", bus.rsp_rdata); end
    checks++; if (bus.rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error got=%b exp=0", bus.rsp_error); end
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got=%b exp=0", bus.mem_valid); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wstrb !== 4'h0) begin errors++; $display("FAIL reset_mem_wstrb got=%b exp=0", bus.mem_wstrb); end
    checks++; if (bus.timeout_seen !== 1'b0) begin errors++; $display("FAIL reset_timeout_seen got=%b exp=0", bus.timeout_seen); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    step();
    bus.req_valid = 2'b01;
    bus.req_addr  = {32'h0, 32'h0000_0100};
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rd_req_ready got=%b exp=01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL rd_mem_valid got=%b exp=1", bus.mem_valid); end
    checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL rd_mem_addr got=%h exp=100", bus.mem_addr); end
    checks++; if (bus.mem_wstrb !== 4'h0) begin errors++; $display("FAIL rd_mem_wstrb got=%b exp=0000", bus.mem_wstrb); end
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rd_mem_valid_wait got=%b exp=0", bus.mem_valid); end
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_rsp_early got=%b exp=00", bus.rsp_valid); end
    step();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL rd_rsp_valid got=%b exp=01", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rsp_rdata got=%h exp=deadbeef", bus.rsp_rdata); end
    checks++; if (bus.rsp_error !== 1'b0) begin errors++; $display("FAIL rd_rsp_error got=%b exp=0", bus.rsp_error); end
    step();
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_rsp_one_cycle got=%b exp=00", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rsp_hold got=%h exp=deadbeef", bus.rsp_rdata); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [31:0] exp_a;
    do_reset();
    step();
    bus.req_valid = 2'b11;
    bus.req_addr  = {32'h0000_2000, 32'h0000_1000};
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? 32'h1000 : 32'h2000;
      #1;
      checks++; if (bus.req_ready !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, bus.req_ready, exp_g); end
      step();
      checks++; if (bus.mem_addr !== exp_a) begin errors++; $display("FAIL rr_mem_addr[%0d] got=%h exp=%h", k, bus.mem_addr, exp_a); end
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rr_ready_busy[%0d] got=%b exp=00", k, bus.req_ready); end
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hA0 + k;
      step();
      bus.mem_rvalid = 1'b0;
      checks++; if (bus.rsp_valid !== exp_g) begin errors++; $display("FAIL rr_rsp_valid[%0d] got=%b exp=%b", k, bus.rsp_valid, exp_g); end
      checks++; if (bus.rsp_rdata !== 32'hA0 + k) begin errors++; $display("FAIL rr_rsp_rdata[%0d] got=%h exp=%h", k, bus.rsp_rdata, 32'hA0 + k); end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_write_hold();
    do_reset();
    step();
    bus.req_valid = 2'b10;
    bus.req_addr  = {32'h0000_0300, 32'h0};
    bus.req_wdata = {32'h1234_5678, 32'h0};
    bus.req_wstrb = {4'b0011, 4'b0000};
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL wr_req_ready got=%b exp=10", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    bus.req_addr  = '1;
    bus.req_wdata = '1;
    bus.req_wstrb = '1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL wr_mem_valid[%0d] got=%b exp=1", i, bus.mem_valid); end
      checks++; if (bus.mem_wstrb !== 4'b0011) begin errors++; $display("FAIL wr_mem_wstrb[%0d] got=%b exp=0011", i, bus.mem_wstrb); end
      checks++; if (bus.mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_mem_wdata[%0d] got=%h exp=12345678", i, bus.mem_wdata); end
      step();
    end
    checks++; if (bus.mem_addr !== 32'h300) begin errors++; $display("FAIL wr_mem_addr got=%h exp=300", bus.mem_addr); end
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL wr_mem_valid_wait got=%b exp=0", bus.mem_valid); end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000_ACED;
    step();
    bus.mem_rvalid = 1'b0;
    checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("FAIL wr_rsp_valid got=%b exp=10", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0000_ACED) begin errors++; $display("FAIL wr_rsp_rdata got=%h exp=0000aced", bus.rsp_rdata); end
    step();
    idle_inputs();
  endtask

  // Runs straight after the write so rsp_rdata is non-zero going in.
  task automatic test_timeout();
    int n;
    step();
    bus.req_valid = 2'b01;
    bus.req_addr  = {32'h0, 32'h0000_0400};
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL to_req_ready got=%b exp=01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    checks++; if (bus.timeout_seen !== 1'b0) begin errors++; $display("FAIL to_seen_before got=%b exp=0", bus.timeout_seen); end
    n = 0;
    while (bus.rsp_valid == 2'b00 && n < 20) begin
      step();
      n++;
    end
    checks++; if (n != 9) begin errors++; $display("FAIL to_latency got=%0d exp=9", n); end
    checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL to_rsp_valid got=%b exp=01", bus.rsp_valid); end
    checks++; if (bus.rsp_error !== 1'b1) begin errors++; $display("FAIL to_rsp_error got=%b exp=1", bus.rsp_error); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_rsp_rdata got=%h exp=0", bus.rsp_rdata); end
    checks++; if (bus.timeout_seen !== 1'b1) begin errors++; $display("FAIL to_seen got=%b exp=1", bus.timeout_seen); end
    step();
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL to_rsp_one_cycle got=%b exp=00", bus.rsp_valid); end
    checks++; if (bus.timeout_seen !== 1'b1) begin errors++; $display("FAIL to_seen_sticky got=%b exp=1", bus.timeout_seen); end
  endtask

  // Runs straight after the timeout: rsp_error and timeout_seen are 1 going in.
  task automatic test_reset_mid();
    step();
    bus.req_valid = 2'b10;
    bus.req_addr  = {32'h0000_0500, 32'h0};
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL rm_req_ready got=%b exp=10", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rm_mem_valid got=%b exp=0", bus.mem_valid); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rm_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (bus.rsp_error !== 1'b0) begin errors++; $display("FAIL rm_rsp_error got=%b exp=0", bus.rsp_error); end
    checks++; if (bus.timeout_seen !== 1'b0) begin errors++; $display("FAIL rm_timeout_seen got=%b exp=0", bus.timeout_seen); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_rsp_valid got=%b exp=00", bus.rsp_valid); end
    step();
    reset = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      bus.mem_rvalid = 1'b0;
      checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_late_rvalid[%0d] got=%b exp=00", i, bus.rsp_valid); end
    end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rm_rsp_rdata got=%h exp=0", bus.rsp_rdata); end
  endtask

  task automatic test_spurious_rvalid();
    do_reset();
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h99;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL sp_rsp_valid[%0d] got=%b exp=00", i, bus.rsp_valid); end
      checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL sp_mem_valid[%0d] got=%b exp=0", i, bus.mem_valid); end
    end
    bus.mem_rvalid = 1'b0;
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL sp_rsp_rdata got=%h exp=0", bus.rsp_rdata); end
    bus.req_valid = 2'b01;
    bus.req_addr  = {32'h0, 32'h0000_0600};
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL sp_still_idle got=%b exp=01", bus.req_ready); end
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_hold();
    test_timeout();
    test_reset_mid();
    test_spurious_rvalid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
